// File: rtl/set_sched_pkg.sv
// set_sched_pkg: shared types and widths for the SET job scheduler.
//   sched_state_e : scheduler FSM states
//   job_t         : one job's engine inputs (central, radius, mode)
//   *_W           : field widths; TIMEOUT_DEF is the default watchdog limit
package set_sched_pkg;
  localparam int CENTRAL_W   = 24;
  localparam int RADIUS_W    = 12;
  localparam int MODE_W      = 2;
  localparam int CAND_W      = 8;
  localparam int TIMEOUT_DEF = 127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } sched_state_e;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } job_t;
endpackage

// File: rtl/set_rr_arbiter.sv
// set_rr_arbiter: combinational round-robin pick.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   gnt_o : one-hot grant (0 when no request)
//   idx_o : index of granted requester
//   any_o : at least one request present
module set_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % NREQ]) begin
        any_o = 1'b1;
        idx_o = IDW'((int'(ptr_i) + i) % NREQ);
        gnt_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/set_job_scheduler.sv
// set_job_scheduler: shares one SET circle-membership engine among NREQ
// requesters. Jobs are granted round-robin, launched with a one-cycle
// eng_en, and the candidate count is returned tagged with requester id.
//   clk, rst              : clock, synchronous active-high reset
//   req/req_central/req_radius/req_mode : per-requester job request + fields
//   gnt                   : one-hot grant pulse; fields sampled that cycle
//   res_valid/res_ready   : result handshake; res_id, res_candidate, res_err
//   eng_*                 : engine launch, held job inputs, engine status/result
// Optional: SET_SCHED_TIMEOUT_EN adds a WAIT watchdog that returns res_err=1.
module set_job_scheduler
  import set_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*CENTRAL_W-1:0]  req_central,
  input  logic [NREQ*RADIUS_W-1:0]   req_radius,
  input  logic [NREQ*MODE_W-1:0]     req_mode,
  output logic [NREQ-1:0]            gnt,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [IDW-1:0]             res_id,
  output logic [CAND_W-1:0]          res_candidate,
  output logic                       res_err,
  output logic                       eng_en,
  output logic [CENTRAL_W-1:0]       eng_central,
  output logic [RADIUS_W-1:0]        eng_radius,
  output logic [MODE_W-1:0]          eng_mode,
  input  logic                       eng_busy,
  input  logic                       eng_valid,
  input  logic [CAND_W-1:0]          eng_candidate
);
  sched_state_e      state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    cur_id_q, cur_id_d;
  job_t              job_q, job_d, job_sel;
  logic [CAND_W-1:0] cand_q, cand_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDW-1:0]    arb_idx;
  logic              arb_any;
  logic              grant_ok;

`ifdef SET_SCHED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  set_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // rst gate keeps gnt low while reset is held even though state is IDLE.
  assign grant_ok = (state_q == S_IDLE) && arb_any && !eng_busy && !rst;

  always_comb begin
    job_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDW'(i)) begin
        job_sel.central = req_central[i*CENTRAL_W +: CENTRAL_W];
        job_sel.radius  = req_radius[i*RADIUS_W +: RADIUS_W];
        job_sel.mode    = req_mode[i*MODE_W +: MODE_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    job_d    = job_q;
    cand_d   = cand_q;
`ifdef SET_SCHED_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          job_d    = job_sel;
          cur_id_d = arb_idx;
          ptr_d    = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
`ifdef SET_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_valid) begin
          cand_d  = eng_candidate;
`ifdef SET_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_DRAIN;
        end
`ifdef SET_SCHED_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          // Counter reaches TIMEOUT on this edge: give up, skip DRAIN.
          if (cnt_q == 8'(TIMEOUT - 1)) begin
            cand_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
`endif
      end
      S_DRAIN: begin
        if (!eng_busy) state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      job_q    <= '0;
      cand_q   <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      job_q    <= job_d;
      cand_q   <= cand_d;
`ifdef SET_SCHED_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign gnt           = grant_ok ? arb_gnt : '0;
  assign eng_en        = (state_q == S_LAUNCH);
  assign res_valid     = (state_q == S_RESP);
  assign res_id        = cur_id_q;
  assign res_candidate = cand_q;
  assign eng_central   = job_q.central;
  assign eng_radius    = job_q.radius;
  assign eng_mode      = job_q.mode;
`ifdef SET_SCHED_TIMEOUT_EN
  assign res_err       = err_q;
`else
  assign res_err       = 1'b0;
`endif
endmodule

// File: doc/set_job_scheduler.md
# set_job_scheduler

Sequencer and round-robin arbiter that shares one SET circle-membership engine among NREQ requesters. It accepts jobs (central, radius, mode) through per-requester req/gnt handshakes and launches each job on the engine with a one-cycle en pulse. It holds all engine inputs stable for the whole job, captures the engine's candidate count, and returns it tagged with the requester id on a valid/ready result port.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester id width
- TIMEOUT, 127, watchdog limit in cycles (used only with SET_SCHED_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester job request, level, held until gnt
- req_central  in  NREQ*24  packed {x1,y1,x2,y2,x3,y3} per requester, slot i at [24i+23:24i]
- req_radius  in  NREQ*12  packed {r1,r2,r3} per requester
- req_mode  in  NREQ*2  per-requester mode 0..3
- gnt  out  NREQ  one-hot, one-cycle pulse; job fields sampled that cycle
- res_valid  out  1  result available, held until accepted
- res_ready  in  1  result consumer ready
- res_id  out  IDW  requester index of result
- res_candidate  out  8  engine candidate count
- res_err  out  1  timeout flag; constant 0 without SET_SCHED_TIMEOUT_EN
- eng_en  out  1  engine start pulse
- eng_central  out  24  engine central
- eng_radius  out  12  engine radius
- eng_mode  out  2  engine mode, stable for entire job
- eng_busy  in  1  engine busy
- eng_valid  in  1  engine valid (level; cleared by engine only at next en)
- eng_candidate  in  8  engine result

## Operation
- States: IDLE, LAUNCH, WAIT, DRAIN, RESP.
- IDLE: if any req and eng_busy==0, round-robin pick starting at pointer ptr; gnt[k] asserted combinationally that cycle; fields of slot k latched at the edge; cur_id<=k; ptr<=(k+1) mod NREQ; next LAUNCH. No req: stay.
- LAUNCH: eng_en=1 exactly this cycle; next WAIT.
- WAIT: on eng_valid==1, capture eng_candidate into res_candidate, res_err<=0; next DRAIN. eng_valid is ignored in LAUNCH because it is stale from the previous job.
- DRAIN: wait eng_busy==0; next RESP.
- RESP: res_valid=1, res_id=cur_id. On res_valid&&res_ready: next IDLE.
- eng_central/radius/mode come from job registers; they change only on a grant edge.
- gnt is never asserted outside IDLE. Requests arriving during a job wait at most NREQ-1 jobs (fairness).
- Reset mid-operation: state IDLE, ptr 0, job registers 0, and all outputs 0 on the next edge. A pending result is discarded.

## Timing
- Reset values: gnt 0, eng_en 0, eng_central/radius/mode 0, res_valid 0, res_id 0, res_candidate 0, res_err 0.
- Grant cycle G: eng_en high at G+1. First possible capture is G+2 (engine dependent).
- Result: res_valid rises 2 cycles after eng_valid first seen (WAIT->DRAIN->RESP) when eng_busy drops in one cycle.
- Back-to-back: next gnt no earlier than the cycle after the res handshake.
- res_candidate/res_id/res_err stable while res_valid&&!res_ready.

## Configuration
- SET_SCHED_TIMEOUT_EN defined: 8-bit counter cleared at LAUNCH and incremented in WAIT. When it reaches TIMEOUT without eng_valid: res_candidate<=0, res_err<=1, and the state goes directly to RESP, skipping DRAIN. eng_busy is not waited on. IDLE still requires eng_busy==0 before granting.
- Undefined: no counter. WAIT is unbounded. res_err tied 0.

## Structure
- Package set_sched_pkg: state enum, field widths (CENTRAL_W 24, RADIUS_W 12, MODE_W 2, CAND_W 8), TIMEOUT default.
- Sub-module set_rr_arbiter (NREQ): combinational round-robin pick given req and ptr. Outputs one-hot grant, index, any.

## Test plan
- Single job, req0 central 24'h440000, radius 12'h300, mode 0 -> gnt[0] one cycle, eng_en one cycle later, res_id 0, res_candidate 29, res_err 0.
- req0 and req1 both high continuously in IDLE, ptr 0 -> grant order 0,1,0,1. With req0..3 all high, order 0,1,2,3,0.
- res_ready held low 10 cycles after res_valid -> res_valid, res_id, res_candidate stable. No gnt until handshake. eng_en not re-asserted.
- Mode held: job mode 2 granted while requester changes req_mode mid-job -> eng_mode stays 2 until next grant. Result matches the bench SET model.
- With SET_SCHED_TIMEOUT_EN, bench engine never asserts eng_valid -> res_valid at TIMEOUT+1 cycles after eng_en with res_err 1, res_candidate 0.
- rst asserted during WAIT -> next edge: state IDLE, all outputs 0, ptr 0. After release, req2 alone -> gnt[2] and normal completion.
